// File: rtl/user_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : user_gpio_bank
//  Description : Wishbone-controlled GPIO bank. Drives NCH pads, samples them
//                through synchronisers (and an optional debounce filter
//                enabled by USER_GPIO_DEBOUNCE_EN) and raises rise/fall IRQs.
//  Revision    : 1.0 - initial release
// ============================================================================
module user_gpio_bank #(
    parameter int          NCH       = 16,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter int          DB_CYCLES = 4
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    input  logic [NCH-1:0] io_in,
    output logic [NCH-1:0] io_out,
    output logic [NCH-1:0] io_oeb,
    output logic [2:0]     irq
);

    localparam logic [7:0] c_off_out     = 8'h00;
    localparam logic [7:0] c_off_oeb     = 8'h04;
    localparam logic [7:0] c_off_in      = 8'h08;
    localparam logic [7:0] c_off_rise_en = 8'h0C;
    localparam logic [7:0] c_off_fall_en = 8'h10;
    localparam logic [7:0] c_off_rise_st = 8'h14;
    localparam logic [7:0] c_off_fall_st = 8'h18;

    logic           r_ack;
    logic [31:0]    r_dat;
    logic [NCH-1:0] r_out;
    logic [NCH-1:0] r_oeb;
    logic [NCH-1:0] r_rise_en;
    logic [NCH-1:0] r_fall_en;
    logic [NCH-1:0] r_rise_st;
    logic [NCH-1:0] r_fall_st;
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_prev;

    logic           w_hit;
    logic           w_req;
    logic           w_wr;
    logic [7:0]     w_off;
    logic [NCH-1:0] w_lane_mask;
    logic [NCH-1:0] w_wr_bits;
    logic [NCH-1:0] w_in;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_fall;
    logic [NCH-1:0] w_rise_clr;
    logic [NCH-1:0] w_fall_clr;
    logic [NCH-1:0] w_rd_bits;
    logic [31:0]    w_rd_word;
    logic           w_unused_ok;

    function automatic logic [NCH-1:0] f_merge(
        input logic [NCH-1:0] old_v,
        input logic [NCH-1:0] new_v,
        input logic [NCH-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // A new request is refused while ack is high, giving the 2-cycle minimum.
    assign w_hit     = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign w_req     = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    assign w_wr      = w_req & wbs_we_i;
    assign w_off     = wbs_adr_i[7:0];
    assign w_wr_bits = wbs_dat_i[NCH-1:0];

    // Bits of wbs_dat_i beyond NCH have no register behind them.
    assign w_unused_ok = &{1'b0, wbs_dat_i};

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_lane
            assign w_lane_mask[i] = wbs_sel_i[i / 8];
        end
    endgenerate

    assign w_rise_clr = (w_wr && (w_off == c_off_rise_st)) ? (w_wr_bits & w_lane_mask) : '0;
    assign w_fall_clr = (w_wr && (w_off == c_off_fall_st)) ? (w_wr_bits & w_lane_mask) : '0;

    always_comb begin
        w_rd_bits = '0;
        case (w_off)
            c_off_out:     w_rd_bits = r_out;
            c_off_oeb:     w_rd_bits = r_oeb;
            c_off_in:      w_rd_bits = w_in;
            c_off_rise_en: w_rd_bits = r_rise_en;
            c_off_fall_en: w_rd_bits = r_fall_en;
            c_off_rise_st: w_rd_bits = r_rise_st;
            c_off_fall_st: w_rd_bits = r_fall_st;
            default:       w_rd_bits = '0;
        endcase
        w_rd_word            = '0;
        w_rd_word[NCH-1:0]   = w_rd_bits;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rd_word : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out     <= '0;
            r_oeb     <= '1;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_off)
                c_off_out:     r_out     <= f_merge(r_out,     w_wr_bits, w_lane_mask);
                c_off_oeb:     r_oeb     <= f_merge(r_oeb,     w_wr_bits, w_lane_mask);
                c_off_rise_en: r_rise_en <= f_merge(r_rise_en, w_wr_bits, w_lane_mask);
                c_off_fall_en: r_fall_en <= f_merge(r_fall_en, w_wr_bits, w_lane_mask);
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            r_prev  <= w_in;
        end
    end

`ifdef USER_GPIO_DEBOUNCE_EN
    localparam int c_cnt_w = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_db
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_filt;

            // Output flips only after DB_CYCLES consecutive differing samples.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (r_sync2[i] == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_cnt  <= '0;
                    r_filt <= r_sync2[i];
                end else begin
                    r_cnt  <= r_cnt + c_cnt_w'(1);
                end
            end

            assign w_in[i] = r_filt;
        end
    endgenerate
`else
    assign w_in = r_sync2;
`endif

    assign w_rise = w_in & ~r_prev;
    assign w_fall = ~w_in & r_prev;

    // A fresh event in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rise_st <= '0;
            r_fall_st <= '0;
        end else begin
            r_rise_st <= (r_rise_st & ~w_rise_clr) | (w_rise & r_rise_en);
            r_fall_st <= (r_fall_st & ~w_fall_clr) | (w_fall & r_fall_en);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_out;
    assign io_oeb    = r_oeb;
    assign irq[0]    = |r_rise_st;
    assign irq[1]    = |r_fall_st;
    assign irq[2]    = (|r_rise_st) | (|r_fall_st);

endmodule
`default_nettype wire

// File: tb/tb_user_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_gpio_bank
//  Description : Self-checking bench for user_gpio_bank with a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_user_gpio_bank;

    localparam int NCH = 16;
    localparam int DB  = 4;
`ifdef USER_GPIO_DEBOUNCE_EN
    localparam int EXTRA = DB;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic [15:0] io_in = 16'h0;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [2:0]  irq;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    user_gpio_bank #(.NCH(NCH), .BASE_ADR(32'h3000_0000), .DB_CYCLES(DB)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_out, m_oeb, m_ren, m_fen, m_rst_st, m_fst_st;
    logic [15:0] m_in, m_in_last;
    logic [15:0] hist [0:15];
    logic        m_ack;
    logic [31:0] m_dat;
    logic        m_req;
    logic [31:0] m_rd;
    logic [15:0] m_mask, m_wd, m_rclr, m_fclr, m_new_in;
    logic        m_flip;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_out = 16'h0; m_oeb = 16'hFFFF; m_ren = 16'h0; m_fen = 16'h0;
            m_rst_st = 16'h0; m_fst_st = 16'h0; m_in = 16'h0; m_in_last = 16'h0;
            m_ack = 1'b0; m_dat = 32'h0;
            for (int k = 0; k < 16; k++) hist[k] = 16'h0;
        end else begin
            m_req  = cyc && stb && (adr[31:8] == 24'h30_0000) && !m_ack;
            m_mask = {{8{sel[1]}}, {8{sel[0]}}};
            m_wd   = dat_i[15:0];
            m_rd   = 32'h0;
            if (m_req) begin
                case (adr[7:0])
                    8'h00: m_rd = {16'h0, m_out};
                    8'h04: m_rd = {16'h0, m_oeb};
                    8'h08: m_rd = {16'h0, m_in};
                    8'h0C: m_rd = {16'h0, m_ren};
                    8'h10: m_rd = {16'h0, m_fen};
                    8'h14: m_rd = {16'h0, m_rst_st};
                    8'h18: m_rd = {16'h0, m_fst_st};
                    default: m_rd = 32'h0;
                endcase
            end
            m_rclr = (m_req && we && adr[7:0] == 8'h14) ? (m_wd & m_mask) : 16'h0;
            m_fclr = (m_req && we && adr[7:0] == 8'h18) ? (m_wd & m_mask) : 16'h0;
            m_rst_st = (m_rst_st & ~m_rclr) | (m_in & ~m_in_last & m_ren);
            m_fst_st = (m_fst_st & ~m_fclr) | (~m_in & m_in_last & m_fen);
            if (m_req && we) begin
                case (adr[7:0])
                    8'h00: m_out = (m_out & ~m_mask) | (m_wd & m_mask);
                    8'h04: m_oeb = (m_oeb & ~m_mask) | (m_wd & m_mask);
                    8'h0C: m_ren = (m_ren & ~m_mask) | (m_wd & m_mask);
                    8'h10: m_fen = (m_fen & ~m_mask) | (m_wd & m_mask);
                    default: ;
                endcase
            end
            m_ack = m_req;
            m_dat = m_req ? m_rd : 32'h0;
            // hist[k] holds io_in as sampled k edges ago
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = io_in;
            m_in_last = m_in;
`ifdef USER_GPIO_DEBOUNCE_EN
            m_new_in = m_in;
            for (int b = 0; b < 16; b++) begin
                m_flip = 1'b1;
                for (int k = 2; k < DB + 2; k++)
                    if (hist[k][b] == m_in[b]) m_flip = 1'b0;
                if (m_flip) m_new_in[b] = ~m_in[b];
            end
`else
            m_new_in = hist[1];
`endif
            m_in = m_new_in;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("ack", {31'h0, ack}, {31'h0, m_ack});
            if (m_ack) check("dat_o", dat_o, m_dat);
            check("io_out", {16'h0, io_out}, {16'h0, m_out});
            check("io_oeb", {16'h0, io_oeb}, {16'h0, m_oeb});
            check("irq", {29'h0, irq},
                  {29'h0, (|m_rst_st) | (|m_fst_st), |m_fst_st, |m_rst_st});
        end
    end

    // ---------------- WB helpers (call at a negedge) ----------------
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic got,
                           output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        got = 1'b0; rd = 32'h0; lat = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            lat = k + 1;
            if (ack) begin got = 1'b1; rd = dat_o; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic got; int lat;
        wb_xfer(1'b1, a, d, s, rd, got, lat);
        check("wr_ack_seen", {31'h0, got}, 32'h1);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd);
        logic got; int lat;
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd, got, lat);
        check("rd_ack_seen", {31'h0, got}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        got;
        int          lat;

        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // reset state
        check("rst_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("rst_out", {16'h0, io_out}, 32'h0);
        check("rst_irq", {29'h0, irq}, 32'h0);
        wb_rd(32'h3000_0004, rd);
        check("rst_rd_oeb", rd, 32'h0000_FFFF);

        // byte-lane write to OUT
        @(negedge clk);
        wb_xfer(1'b1, 32'h3000_0000, 32'h0000_A5A5, 4'b0001, rd, got, lat);
        check("wr_out_lat", lat, 1);
        check("wr_out_io", {16'h0, io_out}, 32'h0000_00A5);
        @(negedge clk);
        wb_rd(32'h3000_0000, rd);
        check("rd_out", rd, 32'h0000_00A5);
        @(negedge clk);
        wb_wr(32'h3000_0004, 32'h0000_1234, 4'b0010);
        check("wr_oeb_lane1", {16'h0, io_oeb}, 32'h0000_12FF);

        // IN register
        io_in = 16'h5A00;
        repeat (5 + EXTRA) @(negedge clk);
        wb_rd(32'h3000_0008, rd);
        check("rd_in", rd, 32'h0000_5A00);
        io_in = 16'h0000;
        repeat (5 + EXTRA) @(negedge clk);

        // rise detection on bit 3 with exact latency
        wb_wr(32'h3000_000C, 32'h0000_0008, 4'hF);
        repeat (2) @(negedge clk);
        io_in[3] = 1'b1;
        repeat (2 + EXTRA) @(negedge clk);
        check("rise_irq_early", {29'h0, irq}, 32'h0);
        @(negedge clk);
        check("rise_irq", {29'h0, irq}, 32'h5);
        wb_rd(32'h3000_0014, rd);
        check("rise_st", rd, 32'h8);
        @(negedge clk);
        wb_wr(32'h3000_0014, 32'h0000_0008, 4'hF);
        check("w1c_irq", {29'h0, irq}, 32'h0);

        // set and W1C hitting the same edge
        io_in[3] = 1'b0;
        repeat (6 + EXTRA) @(negedge clk);
        io_in[3] = 1'b1;
        repeat (2 + EXTRA) @(negedge clk);
        wb_wr(32'h3000_0014, 32'h0000_0008, 4'hF);
        check("setwins_irq", {31'h0, irq[0]}, 32'h1);
        @(negedge clk);
        wb_rd(32'h3000_0014, rd);
        check("setwins_st", rd, 32'h8);
        @(negedge clk);
        wb_wr(32'h3000_0014, 32'h0000_0008, 4'hF);
        check("clr_after_setwins", {29'h0, irq}, 32'h0);

        // fall detection on bit 5
        wb_wr(32'h3000_0010, 32'h0000_0020, 4'hF);
        io_in[5] = 1'b1;
        repeat (6 + EXTRA) @(negedge clk);
        check("fall_none_yet", {29'h0, irq}, 32'h0);
        io_in[5] = 1'b0;
        repeat (6 + EXTRA) @(negedge clk);
        check("fall_irq", {29'h0, irq}, 32'h6);
        wb_rd(32'h3000_0018, rd);
        check("fall_st", rd, 32'h20);
        @(negedge clk);
        wb_wr(32'h3000_0018, 32'h0000_0020, 4'b0001);
        check("fall_clr", {29'h0, irq}, 32'h0);

        // reset during a request cycle
        @(negedge clk);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        adr = 32'h3000_0000; dat_i = 32'h0000_FFFF; sel = 4'hF;
        @(negedge clk);
        check("rstmid_ack", {31'h0, ack}, 32'h0);
        check("rstmid_out", {16'h0, io_out}, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_out_after", {16'h0, io_out}, 32'h0);

        // out-of-window and unmapped offset
        wb_xfer(1'b1, 32'h3000_0100, 32'h0000_FFFF, 4'hF, rd, got, lat);
        check("oow_no_ack", {31'h0, got}, 32'h0);
        check("oow_out", {16'h0, io_out}, 32'h0);
        @(negedge clk);
        wb_wr(32'h3000_001C, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        wb_rd(32'h3000_001C, rd);
        check("rd_1c", rd, 32'h0);

`ifdef USER_GPIO_DEBOUNCE_EN
        // glitch rejection and debounce latency on bit 0
        @(negedge clk);
        wb_wr(32'h3000_000C, 32'h0000_0001, 4'hF);
        io_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        io_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        wb_rd(32'h3000_0008, rd);
        check("db_glitch_in", rd, 32'h0);
        check("db_glitch_irq", {29'h0, irq}, 32'h0);
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("db_irq_early", {29'h0, irq}, 32'h0);
        @(negedge clk);
        check("db_irq", {29'h0, irq}, 32'h5);
        wb_rd(32'h3000_0008, rd);
        check("db_in", rd, 32'h1);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
